johnson_step_sequencer: RTL and testbench

- Controller that sequences a 2·WIDTH-state twisted-ring (Johnson) phase register for multi-phase enable / stepper-style outputs.
- Accepts a start/stop command with a programmable step period, step count and direction.
- Advances the phase once per period and reports progress and completion.
- Recovers the phase register from illegal (non-Johnson) codes.

---
 rtl/johnson_seq_pkg.sv | 51 +++++
 rtl/johnson_core.sv | 46 ++++
 rtl/johnson_step_sequencer.sv | 101 ++++++++++
 tb/tb_johnson_step_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_seq_pkg.sv
// Shared types and Johnson-code helpers for the step sequencer.
// Helpers work on a fixed-width word; callers pass the live ring width.
package johnson_seq_pkg;

  localparam int unsigned JOHNSON_MAX_W = 32;

  typedef logic [JOHNSON_MAX_W-1:0] jword_t;

  localparam jword_t JONE = jword_t'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic jword_t johnson_mask(input int unsigned width);
    return (width >= JOHNSON_MAX_W) ? '1 : ((JONE << width) - JONE);
  endfunction

  // Twisted-ring shift: the bit leaving one end re-enters inverted at the other.
  function automatic jword_t johnson_next(input jword_t phase, input logic dir,
                                          input int unsigned width);
    jword_t mask;
    jword_t top;
    jword_t p;
    jword_t r;
    logic   msb;
    logic   lsb;
    mask = johnson_mask(width);
    top  = JONE << (width - 1);
    p    = phase & mask;
    msb  = |(p & top);
    lsb  = p[0];
    if (!dir) r = ((p << 1) | (msb ? '0 : JONE)) & mask;
    else      r = ((p >> 1) | (lsb ? '0 : top)) & mask;
    return r;
  endfunction

  // Legal codes are a run of ones anchored at bit 0, or its complement.
  function automatic logic johnson_legal(input jword_t phase, input int unsigned width);
    jword_t mask;
    jword_t a;
    jword_t b;
    mask = johnson_mask(width);
    a    = phase & mask;
    b    = ~a & mask;
    return (((a & (a + JONE)) & mask) == '0) || (((b & (b + JONE)) & mask) == '0);
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson phase register: advances on step, forces an illegal code back to
// all-zeros instead of advancing, and flags that correction for one cycle.
module johnson_core
  import johnson_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] phase,
  output logic             err_recover
);

  jword_t phase_wide;
  jword_t next_wide;
  logic   legal;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    phase_wide              = '0;
    phase_wide[WIDTH-1:0]   = phase;
    next_wide               = johnson_next(phase_wide, dir, WIDTH);
    legal                   = johnson_legal(phase_wide, WIDTH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase       <= '0;
      err_recover <= 1'b0;
    end else begin
      err_recover <= 1'b0;
      if (step) begin
        if (legal) begin
          phase <= next_wide[WIDTH-1:0];
        end else begin
          phase       <= '0;
          err_recover <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/johnson_step_sequencer.sv
// Step sequencer: command FSM, step-period prescaler and progress counter
// driving a Johnson phase register. All outputs are registered.
module johnson_step_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] phase,
  output logic             step_strobe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_done,
  output logic             err_recover
);

  seq_state_e       state;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] steps_q;
  logic             dir_q;
  logic             step_en;
  logic             last_step;

  // stop beats a pending step in the same cycle.
  assign step_en   = (state == ST_RUN) && !stop && (presc == '0);
  assign last_step = (steps_q != '0) && ((steps_done + 1'b1) == steps_q);

  johnson_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .step       (step_en),
    .dir        (dir_q),
    .phase      (phase),
    .err_recover(err_recover)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      presc       <= '0;
      div_q       <= '0;
      steps_q     <= '0;
      dir_q       <= 1'b0;
      steps_done  <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= step_en;
      done        <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            div_q      <= div;
            steps_q    <= steps;
            dir_q      <= dir;
            presc      <= div;
            steps_done <= '0;
            state      <= ST_RUN;
            busy       <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (presc != '0) begin
            presc <= presc - 1'b1;
          end else begin
            steps_done <= steps_done + 1'b1;
            presc      <= div_q;
            if (last_step) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Scoreboard bench: each run's step events are predicted from a Johnson
// position index and checked by a monitor whenever step_strobe appears.
module tb_johnson_step_sequencer;

  localparam int W    = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int NPH  = 2 * W;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          dir;
  logic [DW-1:0] div;
  logic [CW-1:0] steps;
  logic [W-1:0]  phase;
  logic          step_strobe;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_done;
  logic          err_recover;

  johnson_step_sequencer #(.WIDTH(W), .DIV_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .div        (div),
    .steps      (steps),
    .phase      (phase),
    .step_strobe(step_strobe),
    .busy       (busy),
    .done       (done),
    .steps_done (steps_done),
    .err_recover(err_recover)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            edge_c;
    logic [W-1:0]  ph;
    logic          err;
    logic          dn;
    logic [CW-1:0] sd;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: position on the 2*W-state ring plus an "illegal" flag.
  int   m_idx     = 0;
  bit   m_illegal = 1'b0;
  int   m_sd      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] code_of(input int idx);
    int v;
    if (idx <= W) v = (1 << idx) - 1;
    else          v = MASK ^ ((1 << (idx - W)) - 1);
    return W'(v);
  endfunction

  // Predict every step of a run started at edge e; stop_at < 0 means no stop.
  task automatic plan(input int e, input int d, input int n, input bit dr, input int stop_at);
    for (int k = 1; k <= 4096; k++) begin
      exp_t x;
      int   edg;
      edg = e + k * (d + 1);
      if (stop_at >= 0 && edg >= stop_at) break;
      if (n != 0 && k > n) break;
      x.err = m_illegal;
      if (m_illegal) begin
        m_idx     = 0;
        m_illegal = 1'b0;
      end else begin
        m_idx = dr ? (m_idx + NPH - 1) % NPH : (m_idx + 1) % NPH;
      end
      m_sd     = k % (1 << CW);
      x.edge_c = edg;
      x.ph     = code_of(m_idx);
      x.dn     = (n != 0) && (k == n);
      x.sd     = CW'(m_sd);
      sb.push_back(x);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // One complete command; stop_rel >= 0 aborts with stop sampled at e+stop_rel.
  task automatic run(input int d, input int n, input bit dr, input int stop_rel, input bit junk);
    int e;
    int target;
    e     = cyc + 1;
    div   = DW'(d);
    steps = CW'(n);
    dir   = dr;
    start = 1'b1;
    stop  = 1'b0;
    m_sd  = 0;
    plan(e, d, n, dr, (stop_rel < 0) ? -1 : e + stop_rel);
    tick;
    check("busy_after_start", 32'(busy), 32'd1);
    start = junk;
    div   = DW'($urandom);
    steps = CW'($urandom);
    dir   = 1'($urandom);
    if (stop_rel >= 0) begin
      target = e + stop_rel;
      while (cyc < target - 1) begin
        tick;
        start = 1'b0;
      end
      stop = 1'b1;
      tick;
      stop  = 1'b0;
      start = 1'b0;
      check("busy_after_stop", 32'(busy), 32'd0);
      check("done_after_stop", 32'(done), 32'd0);
    end else begin
      target = e + n * (d + 1);
      while (cyc < target) begin
        tick;
        start = 1'b0;
      end
      check("busy_at_done", 32'(busy), 32'd0);
      check("steps_done_final", 32'(steps_done), 32'(n));
    end
    check("queue_drained", 32'(sb.size()), 32'd0);
    check("phase_at_end", 32'(phase), 32'(code_of(m_idx)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_outs"}, 32'({step_strobe, busy, done, err_recover}), 32'd0);
    check({tag, "_steps_done"}, 32'(steps_done), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("pulse_without_strobe", 32'({done, err_recover} & {2{~step_strobe}}), 32'd0);
      if (step_strobe) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
        end else begin
          mx = sb.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(mx.edge_c));
          check("strobe_phase", 32'(phase), 32'(mx.ph));
          check("strobe_err", 32'(err_recover), 32'(mx.err));
          check("strobe_done", 32'(done), 32'(mx.dn));
          check("strobe_busy", 32'(busy), 32'(!mx.dn));
          check("strobe_steps_done", 32'(steps_done), 32'(mx.sd));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sd_before;
    int n;
    int d;
    int e;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b0;
    div   = '0;
    steps = '0;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    tick;
    tick;
    reset = 1'b1;
    tick;

    // Forward 3 steps at period 3 from power-up, then rewind to 0000.
    run(2, 3, 1'b0, -1, 1'b0);
    run(1, 3, 1'b1, -1, 1'b0);
    // Reverse 8 steps every cycle: 1000 ... 0000.
    run(0, 8, 1'b1, -1, 1'b0);
    // Continuous forward, 20 steps, then stop: ends at 1111, no done.
    run(0, 0, 1'b0, 21, 1'b0);
    check("continuous_phase", 32'(phase), 32'(4'b1111));
    check("continuous_count", 32'(steps_done), 32'd20);

    // Illegal code injected after start is replaced by 0000 on the next step.
    m_illegal = 1'b1;
    e     = cyc + 1;
    div   = DW'(3);
    steps = CW'(4);
    dir   = 1'b0;
    start = 1'b1;
    m_sd  = 0;
    plan(e, 3, 4, 1'b0, -1);
    tick;
    start = 1'b0;
    force dut.u_core.phase = 4'b0101;
    #1 release dut.u_core.phase;
    while (cyc < e + 16) tick;
    check("err_queue_drained", 32'(sb.size()), 32'd0);
    check("err_final_phase", 32'(phase), 32'(code_of(m_idx)));

    // start+stop in IDLE does nothing.
    sd_before = int'(steps_done);
    start = 1'b1;
    stop  = 1'b1;
    div   = '0;
    steps = CW'(1);
    tick;
    start = 1'b0;
    stop  = 1'b0;
    tick;
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_count", 32'(steps_done), 32'(sd_before));
    check("start_stop_phase", 32'(phase), 32'(code_of(m_idx)));

    // start held into RUN with new settings is ignored.
    run(1, 5, 1'b0, -1, 1'b1);

    // Randomized runs: back-to-back starts, random stops, ignored restarts.
    for (int it = 0; it < 16; it++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) run(d, n, 1'($urandom), $urandom_range(1, n * (d + 1)), 1'($urandom));
      else                           run(d, n, 1'($urandom), -1, 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick;
    end

    // Reset mid-run: everything clears at once, then behaves as from power-up.
    e     = cyc + 1;
    div   = DW'(2);
    steps = CW'(6);
    dir   = 1'b0;
    start = 1'b1;
    m_sd  = 0;
    plan(e, 2, 6, 1'b0, -1);
    tick;
    start = 1'b0;
    for (int g = $urandom_range(1, 14); g > 0; g--) tick;
    #1 reset = 1'b0;
    #1 check_all_zero("midrun_reset");
    sb.delete();
    m_idx     = 0;
    m_illegal = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    run(2, 3, 1'b0, -1, 1'b0);
    check("after_reset_phase", 32'(phase), 32'(4'b0111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
